// File: rtl/and_gate_arbiter_pkg.sv
// Shared types and constants for the round-robin AND-gate arbiter.
// The BIST state exists only when GATE_SELFTEST_EN is defined.
package and_gate_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StResp = 2'd2
`ifdef GATE_SELFTEST_EN
    ,
    StBist = 2'd3
`endif
  } state_e;

  // Self-test vectors, {a,b} per entry, applied in order 00,01,10,11.
  localparam logic [7:0] BistVecs = {2'b11, 2'b10, 2'b01, 2'b00};
  // Expected AND result for each vector above.
  localparam logic [3:0] BistExp  = 4'b1000;

  function automatic logic [1:0] bist_vec(input logic [1:0] idx);
    return BistVecs[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/and_gate_arbiter_gate_eval_core.sv
// Registered WIDTH-wide bitwise AND; captures a & b on clock edges where en is high.
// Shared by the arbitration path and the self-test path.
module and_gate_arbiter_gate_eval_core #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= a & b;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/and_gate_arbiter.sv
// Round-robin arbiter sharing one registered AND core among NREQ requesters.
// Define GATE_SELFTEST_EN to add the built-in self-test (bist_start/bist_done/bist_pass).
module and_gate_arbiter
  import and_gate_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef GATE_SELFTEST_EN
  input  logic                  bist_start,
  output logic                  bist_done,
  output logic                  bist_pass,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic              core_en;
  logic [WIDTH-1:0]  core_a, core_b, core_q;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  int unsigned       cand;

`ifdef GATE_SELFTEST_EN
  logic [2:0]        cnt_q, cnt_d;
  logic              ok_q, ok_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [1:0]        bist_ab;
  logic [1:0]        bist_prev;
  logic              bist_match;
`endif

  // First asserted request at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr_q) + i) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    opa_d       = opa_q;
    opb_d       = opb_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    core_en     = 1'b0;
    core_a      = opa_q;
    core_b      = opb_q;
`ifdef GATE_SELFTEST_EN
    cnt_d      = cnt_q;
    ok_d       = ok_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    bist_ab    = bist_vec(cnt_q[1:0]);
    // Core output lags the applied vector by one cycle.
    bist_prev  = cnt_q[1:0] - 2'd1;
    bist_match = (core_q == {WIDTH{BistExp[bist_prev]}});
`endif

    unique case (state_q)
      StIdle: begin
`ifdef GATE_SELFTEST_EN
        if (bist_start) begin
          state_d = StBist;
          cnt_d   = '0;
          ok_d    = 1'b1;
          pass_d  = 1'b0;
        end else
`endif
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          opa_d          = op_a[win_idx*WIDTH +: WIDTH];
          opb_d          = op_b[win_idx*WIDTH +: WIDTH];
          id_d           = win_idx;
          ptr_d          = ID_W'((32'(win_idx) + 32'd1) % NREQ);
          state_d        = StEval;
        end
      end
      StEval: begin
        core_en = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = core_q;
        state_d     = StIdle;
      end
`ifdef GATE_SELFTEST_EN
      StBist: begin
        if (cnt_q != 3'd4) begin
          core_en = 1'b1;
          core_a  = {WIDTH{bist_ab[1]}};
          core_b  = {WIDTH{bist_ab[0]}};
        end
        if (cnt_q != 3'd0) begin
          ok_d = ok_q & bist_match;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          done_d  = 1'b1;
          pass_d  = ok_q & bist_match;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef GATE_SELFTEST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ok_q   <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign bist_done = done_q;
  assign bist_pass = pass_q;
`endif

  and_gate_arbiter_gate_eval_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (core_en),
    .a     (core_a),
    .b     (core_b),
    .q     (core_q)
  );

  assign gnt       = gnt_q;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Self-checking bench for and_gate_arbiter: directed scenarios plus randomized
// traffic against a round-robin reference model.
module tb_and_gate_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 1;
  localparam int ID_W  = 2;
  localparam int OPW   = NREQ * WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [OPW-1:0]  op_a, op_b;
  logic [NREQ-1:0] gnt;
  logic            busy, rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef GATE_SELFTEST_EN
  logic            bist_start, bist_done, bist_pass;
`endif

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  logic [NREQ-1:0]  eg;
  logic [WIDTH-1:0] ed;
  int               w;

  always #5 clk = ~clk;

  and_gate_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef GATE_SELFTEST_EN
    .bist_start (bist_start),
    .bist_done  (bist_done),
    .bist_pass  (bist_pass),
`endif
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .gnt        (gnt),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  // Reference: first set request at or after the pointer, modulo NREQ; -1 if none.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int o = 0; o < NREQ; o++) begin
      if (r[(p + o) % NREQ]) return (p + o) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
`ifdef GATE_SELFTEST_EN
    bist_start = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
`ifdef GATE_SELFTEST_EN
    bist_start = 1'b0;
`endif
    #2;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_data got %b exp 0", rsp_data); end
    step();
    step();
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    req = 4'b0001; op_a = 4'b0001; op_b = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    req = '0;
    step();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL single_gnt_pulse got %b exp 0", gnt); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_data !== 1'b1) begin errors++; $display("FAIL single_data got %b exp 1", rsp_data); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_strobe got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 1'b1) begin errors++; $display("FAIL single_hold got %b exp 1", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
    m_ptr = 1;
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111; op_a = '1; op_b = '0;
    for (int n = 0; n < 5; n++) begin
      step();
      w  = rr_pick(req, m_ptr);
      eg = onehot(w);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", n, gnt, eg); end
      checks++; if (w != n % NREQ) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", n, w, n % NREQ); end
      step();
      checks++; if (gnt !== '0) begin errors++; $display("FAIL rr_gap[%0d] got %b exp 0", n, gnt); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(w) || rsp_data !== '0) begin
        errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d d=%b exp v=1 id=%0d d=0", n, rsp_valid, rsp_id, rsp_data, w);
      end
      m_ptr = (w + 1) % NREQ;
    end
    req = '0;
    step();
  endtask

  task automatic test_truth_table();
    for (int v = 0; v < 4; v++) begin
      req  = 4'b0100;
      op_a = OPW'($urandom());
      op_b = OPW'($urandom());
      op_a[2*WIDTH +: WIDTH] = {WIDTH{v[1]}};
      op_b[2*WIDTH +: WIDTH] = {WIDTH{v[0]}};
      ed = {WIDTH{v[1] & v[0]}};
      step();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL tt_gnt[%0d] got %b exp 0100", v, gnt); end
      req = '0;
      step();
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== ed) begin
        errors++; $display("FAIL tt_rsp[%0d] got v=%b id=%0d d=%b exp v=1 id=2 d=%b", v, rsp_valid, rsp_id, rsp_data, ed);
      end
      m_ptr = 3;
    end
  endtask

  task automatic test_mid_reset();
    req = 4'b0001; op_a = '1; op_b = '1;
    step();
    eg = onehot(rr_pick(req, m_ptr));
    checks++; if (gnt !== eg) begin errors++; $display("FAIL mr_gnt got %b exp %b", gnt, eg); end
    req = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || gnt !== '0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mr_async got busy=%b gnt=%b v=%b exp 0 0 0", busy, gnt, rsp_valid);
    end
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++; $display("FAIL mr_discard got v=%b d=%b exp 0 0", rsp_valid, rsp_data);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    // Pointer back at 0 means requester 0 wins over 2.
    req = 4'b0101;
    step();
    eg = onehot(rr_pick(req, m_ptr));
    checks++; if (gnt !== eg) begin errors++; $display("FAIL mr_ptr got %b exp %b", gnt, eg); end
    m_ptr = 1;
    req = '0;
    step();
    step();
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mr_gnt2 got %b exp 0100", gnt); end
    m_ptr = 3;
    req = '0;
    step();
    step();
  endtask

  task automatic test_busy_pulse();
    req = 4'b0001; op_a = '0; op_b = '1;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt got %b exp 0001", gnt); end
    m_ptr = 1;
    req = 4'b0010;
    step();
    req = '0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL bp_rsp got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (gnt !== '0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_ignored[%0d] got gnt=%b v=%b exp 0 0", n, gnt, rsp_valid);
      end
    end
  endtask

`ifdef GATE_SELFTEST_EN
  task automatic test_bist();
    bit seen;
    seen = 1'b0;
    req = 4'b0001; op_a = '1; op_b = '1;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    checks++; if (gnt !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL bist_enter got gnt=%b busy=%b exp 0 1", gnt, busy);
    end
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      checks++; if (gnt !== '0) begin errors++; $display("FAIL bist_nognt[%0d] got %b exp 0", n, gnt); end
      if (bist_done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bist_done got 0 exp 1 within 20 cycles"); end
    checks++; if (bist_pass !== 1'b1) begin errors++; $display("FAIL bist_pass got %b exp 1", bist_pass); end
    step();
    eg = onehot(rr_pick(req, m_ptr));
    checks++; if (gnt !== eg) begin errors++; $display("FAIL bist_after_gnt got %b exp %b", gnt, eg); end
    checks++; if (bist_done !== 1'b0 || bist_pass !== 1'b1) begin
      errors++; $display("FAIL bist_hold got done=%b pass=%b exp 0 1", bist_done, bist_pass);
    end
    m_ptr = 1;
    req = '0;
    step();
    step();
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] r;
    logic [OPW-1:0]  a, b;
    for (int it = 0; it < 60; it++) begin
      r = ($urandom_range(3) == 0) ? '0 : NREQ'($urandom());
      a = OPW'($urandom());
      b = OPW'($urandom());
      req = r; op_a = a; op_b = b;
      step();
      w = rr_pick(r, m_ptr);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle_v[%0d] got %b exp 0", it, rsp_valid); end
      if (w < 0) begin
        checks++; if (gnt !== '0 || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_nogrant[%0d] got gnt=%b busy=%b exp 0 0", it, gnt, busy);
        end
      end else begin
        eg = onehot(w);
        ed = a[w*WIDTH +: WIDTH] & b[w*WIDTH +: WIDTH];
        m_ptr = (w + 1) % NREQ;
        checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt[%0d] got %b exp %b", it, gnt, eg); end
        req = NREQ'($urandom()); op_a = OPW'($urandom()); op_b = OPW'($urandom());
        step();
        checks++; if (gnt !== '0) begin errors++; $display("FAIL rnd_busy_gnt[%0d] got %b exp 0", it, gnt); end
        req = NREQ'($urandom()); op_a = OPW'($urandom()); op_b = OPW'($urandom());
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(w) || rsp_data !== ed) begin
          errors++; $display("FAIL rnd_rsp[%0d] got v=%b id=%0d d=%b exp v=1 id=%0d d=%b", it, rsp_valid, rsp_id, rsp_data, w, ed);
        end
      end
    end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_truth_table();
    test_mid_reset();
    test_busy_pulse();
`ifdef GATE_SELFTEST_EN
    test_bist();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
